// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl: direct-mapped instruction cache that refills the demand line plus the next line
module icache_fill_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 128,
  parameter int LINES      = 16,
  parameter int MEM_WAIT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [WORD_SIZE-1:0]  cpu_addr,
  input  logic                  cpu_flush,
  output logic                  cpu_ready,
  output logic [WORD_SIZE-1:0]  cpu_inst,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_block0,
  input  logic [BLOCK_SIZE-1:0] mem_block1
);
  localparam int OFF_W = $clog2(BLOCK_SIZE/8);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = WORD_SIZE-IDX_W-OFF_W;
  localparam int CW    = MEM_WAIT > 1 ? $clog2(MEM_WAIT) : 1;
  localparam int WL    = MEM_WAIT > 0 ? MEM_WAIT-1 : 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_t;
  state_t state, state_nx;
  logic [BLOCK_SIZE-1:0] lines [LINES];
  logic [TAG_W-1:0] tags [LINES];
  logic [LINES-1:0] valid;
  logic [CW-1:0] cnt;
  logic [TAG_W-1:0] tag, ftag, ntag;
  logic [IDX_W-1:0] idx, fidx, nidx;
  logic [OFF_W-1:0] off;
  logic [WORD_SIZE-1:0] nxt_addr;
  logic [BLOCK_SIZE-1:0] line;
  logic lookup, hit;
  assign tag = cpu_addr[WORD_SIZE-1 -: TAG_W];
  assign idx = cpu_addr[OFF_W +: IDX_W];
  // byte offset rounded down to a word; the two low address bits never affect the result
  assign off = cpu_addr[OFF_W-1:0] & ~OFF_W'(3);
  assign line = lines[idx];
  assign lookup = state == IDLE && cpu_req && !cpu_flush;
  assign hit = valid[idx] && tags[idx] == tag;
  assign nxt_addr = mem_addr + WORD_SIZE'(BLOCK_SIZE/8);
  assign ftag = mem_addr[WORD_SIZE-1 -: TAG_W];
  assign fidx = mem_addr[OFF_W +: IDX_W];
  assign ntag = nxt_addr[WORD_SIZE-1 -: TAG_W];
  assign nidx = nxt_addr[OFF_W +: IDX_W];
  assign mem_write = 1'b0;
  assign mem_wdata = '0;
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  // miss detection starts a refill; the refill always returns through IDLE so the held request re-looks-up
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = lookup && !hit ? REQ : IDLE;
      REQ:     state_nx = MEM_WAIT > 0 ? WAIT : FILL;
      WAIT:    state_nx = cnt == CW'(WL) ? FILL : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  // registered CPU/memory outputs, wait counter and valid bits; flush beats a fill landing the same edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ready <= 1'b0;
      cpu_inst <= '0;
      mem_read <= 1'b0;
      mem_addr <= '0;
      valid <= '0;
      cnt <= '0;
    end else begin
      cpu_ready <= lookup && hit;
      if (lookup && hit) cpu_inst <= line[BLOCK_SIZE-1-8*int'(off) -: WORD_SIZE];
      mem_read <= lookup && !hit;
      if (lookup && !hit) mem_addr <= {cpu_addr[WORD_SIZE-1:OFF_W], OFF_W'(0)};
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      if (cpu_flush) valid <= '0;
      else if (state == FILL) begin
        valid[fidx] <= 1'b1;
        valid[nidx] <= 1'b1;
      end
    end
  end
  // line and tag storage written on the capture edge; the prefetch slot is overwritten unconditionally
  always_ff @(posedge clk)
    if (state == FILL) begin
      lines[fidx] <= mem_block0;
      tags[fidx] <= ftag;
      lines[nidx] <= mem_block1;
      tags[nidx] <= ntag;
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// tb_icache_fill_ctrl: randomized and directed checks of the fill controller against a line-address model
module tb_icache_fill_ctrl;
  logic clk = 0, rst_n = 0, cpu_req = 0, cpu_flush = 0;
  logic [31:0] cpu_addr = 0;
  logic cpu_ready, mem_read, mem_write, cpu_ready2, mem_read2, mem_write2;
  logic [31:0] cpu_inst, mem_addr, cpu_inst2, mem_addr2;
  logic [31:0] la = 0, la2 = 0;
  logic [127:0] mem_wdata, mem_block0, mem_block1, mem_wdata2, mem_b0_2, mem_b1_2;
  int n_tests = 0, n_fail = 0;
  logic [31:0] mline [16];
  bit mval [16];

  icache_fill_ctrl #(.MEM_WAIT(0)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_flush(cpu_flush),
    .cpu_ready(cpu_ready), .cpu_inst(cpu_inst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_block0(mem_block0), .mem_block1(mem_block1));

  icache_fill_ctrl #(.MEM_WAIT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_flush(cpu_flush),
    .cpu_ready(cpu_ready2), .cpu_inst(cpu_inst2), .mem_read(mem_read2), .mem_write(mem_write2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_block0(mem_b0_2), .mem_block1(mem_b1_2));

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[31:2], 2'b00} * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  function automatic logic [127:0] line_at(input logic [31:0] a);
    logic [31:0] b = {a[31:4], 4'h0};
    return {word_at(b), word_at(b + 32'd4), word_at(b + 32'd8), word_at(b + 32'd12)};
  endfunction

  always @(posedge clk) begin
    if (mem_read) la <= mem_addr;
    if (mem_read2) la2 <= mem_addr2;
  end
  assign mem_block0 = line_at(la);
  assign mem_block1 = line_at(la + 32'd16);
  assign mem_b0_2 = line_at(la2);
  assign mem_b1_2 = line_at(la2 + 32'd16);

  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] l = {a[31:4], 4'h0};
    return mval[l[7:4]] && mline[l[7:4]] == l;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    logic [31:0] l = {a[31:4], 4'h0};
    logic [31:0] n = l + 32'd16;
    mline[l[7:4]] = l;
    mval[l[7:4]] = 1;
    mline[n[7:4]] = n;
    mval[n[7:4]] = 1;
  endtask

  task automatic m_clear;
    foreach (mval[i]) mval[i] = 0;
  endtask

  task automatic do_reset;
    rst_n = 0;
    cpu_req = 0;
    cpu_flush = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    m_clear();
  endtask

  task automatic fetch(input logic [31:0] a, input bit sel, output int lat, output int nrd,
                       output int rdc, output logic [31:0] inst, output logic [31:0] maddr);
    logic rdy;
    cpu_addr = a;
    cpu_req = 1;
    lat = 0;
    nrd = 0;
    rdc = 0;
    maddr = 32'hDEAD_BEEF;
    do begin
      @(posedge clk);
      #1 lat++;
      if (sel ? mem_read2 : mem_read) begin
        nrd++;
        if (rdc == 0) rdc = lat;
        maddr = sel ? mem_addr2 : mem_addr;
      end
      rdy = sel ? cpu_ready2 : cpu_ready;
    end while (!rdy && lat < 50);
    inst = sel ? cpu_inst2 : cpu_inst;
    cpu_req = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_tests++;
    if ({cpu_ready, mem_read, mem_write, cpu_inst, mem_addr} !== 67'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%b rd=%b wr=%b inst=%h addr=%h expected all zero",
               cpu_ready, mem_read, mem_write, cpu_inst, mem_addr);
    end
    n_tests++;
    if (mem_wdata !== 128'd0) begin
      n_fail++;
      $display("FAIL reset_wdata: got %h expected 0", mem_wdata);
    end
    n_tests++;
    if ({cpu_ready2, mem_read2, mem_write2, cpu_inst2, mem_addr2, mem_wdata2} !== 195'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_wait2: got rdy=%b rd=%b addr=%h expected all zero",
               cpu_ready2, mem_read2, mem_addr2);
    end
  endtask

  task automatic test_miss_fill;
    int lat, nrd, rdc;
    logic [31:0] inst, maddr;
    do_reset();
    fetch(32'h0, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (rdc !== 1 || nrd !== 1 || maddr !== 32'h0) begin
      n_fail++;
      $display("FAIL miss_request: got read_cycle=%0d reads=%0d addr=%h expected 1 1 00000000", rdc, nrd, maddr);
    end
    n_tests++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL miss_latency: got %0d expected 4", lat);
    end
    n_tests++;
    if (inst !== line_at(32'h0) >> 96) begin
      n_fail++;
      $display("FAIL miss_inst: got %h expected %h", inst, word_at(32'h0));
    end
    m_fill(32'h0);
  endtask

  task automatic test_back_to_back;
    int lat, nrd, rdc;
    logic [31:0] inst, maddr;
    logic [31:0] addrs [2] = '{32'h0000000C, 32'h00000010};
    foreach (addrs[i]) begin
      fetch(addrs[i], 0, lat, nrd, rdc, inst, maddr);
      n_tests++;
      if (lat !== 1 || nrd !== 0 || inst !== word_at(addrs[i])) begin
        n_fail++;
        $display("FAIL b2b_hit_%0d: got lat=%0d reads=%0d inst=%h expected 1 0 %h",
                 i, lat, nrd, inst, word_at(addrs[i]));
      end
    end
    @(posedge clk);
    #1 n_tests++;
    if (cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_pulse: got %b expected 0", cpu_ready);
    end
  endtask

  task automatic test_idx_wrap;
    int lat, nrd, rdc;
    logic [31:0] inst, maddr;
    do_reset();
    fetch(32'h000000F4, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 4 || maddr !== 32'h000000F0 || inst !== word_at(32'hF4)) begin
      n_fail++;
      $display("FAIL idx15_miss: got lat=%0d addr=%h inst=%h expected 4 000000f0 %h", lat, maddr, inst, word_at(32'hF4));
    end
    fetch(32'h00000100, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 1 || nrd !== 0 || inst !== word_at(32'h100)) begin
      n_fail++;
      $display("FAIL prefetch_tag1_hit: got lat=%0d reads=%0d inst=%h expected 1 0 %h", lat, nrd, inst, word_at(32'h100));
    end
    fetch(32'h00000000, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 4 || nrd !== 1 || maddr !== 32'h0 || inst !== word_at(32'h0)) begin
      n_fail++;
      $display("FAIL tag0_remiss: got lat=%0d reads=%0d addr=%h inst=%h expected 4 1 0 %h", lat, nrd, maddr, inst, word_at(32'h0));
    end
  endtask

  task automatic test_flush_fill;
    int lat, nrd;
    logic [31:0] maddr;
    do_reset();
    cpu_addr = 32'h00000238;
    cpu_req = 1;
    lat = 0;
    nrd = 0;
    maddr = 0;
    do begin
      @(posedge clk);
      #1 lat++;
      cpu_flush = (lat == 2);
      if (mem_read) begin
        nrd++;
        maddr = mem_addr;
      end
    end while (!cpu_ready && lat < 40);
    cpu_flush = 0;
    n_tests++;
    if (lat !== 7 || nrd !== 2 || maddr !== 32'h00000230) begin
      n_fail++;
      $display("FAIL flush_in_fill: got lat=%0d reads=%0d addr=%h expected 7 2 00000230", lat, nrd, maddr);
    end
    n_tests++;
    if (cpu_inst !== word_at(32'h238)) begin
      n_fail++;
      $display("FAIL flush_refill_inst: got %h expected %h", cpu_inst, word_at(32'h238));
    end
    cpu_flush = 1;
    @(posedge clk);
    #1 cpu_flush = 0;
    n_tests++;
    if (cpu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_beats_hit: got ready=%b expected 0", cpu_ready);
    end
    lat = 0;
    nrd = 0;
    while (!cpu_ready && lat < 40) begin
      @(posedge clk);
      #1 lat++;
      if (mem_read) nrd++;
    end
    cpu_req = 0;
    n_tests++;
    if (lat !== 4 || nrd !== 1) begin
      n_fail++;
      $display("FAIL after_flush_miss: got lat=%0d reads=%0d expected 4 1", lat, nrd);
    end
  endtask

  task automatic test_reset_in_wait;
    int lat, nrd, rdc;
    logic [31:0] inst, maddr;
    do_reset();
    cpu_addr = 32'h00000040;
    cpu_req = 1;
    @(posedge clk);
    #1 n_tests++;
    if (mem_read2 !== 1'b1 || mem_addr2 !== 32'h40) begin
      n_fail++;
      $display("FAIL wait2_request: got rd=%b addr=%h expected 1 00000040", mem_read2, mem_addr2);
    end
    @(posedge clk);
    #1 rst_n = 0;
    cpu_req = 0;
    @(posedge clk);
    #1 n_tests++;
    if (mem_read2 !== 1'b0 || cpu_ready2 !== 1'b0 || mem_addr2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_in_wait: got rd=%b rdy=%b addr=%h expected 0 0 0", mem_read2, cpu_ready2, mem_addr2);
    end
    rst_n = 1;
    m_clear();
    repeat (3) @(posedge clk);
    #1 fetch(32'h00000040, 1, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 6 || nrd !== 1 || maddr !== 32'h40 || inst !== word_at(32'h40)) begin
      n_fail++;
      $display("FAIL wait2_remiss: got lat=%0d reads=%0d addr=%h inst=%h expected 6 1 00000040 %h",
               lat, nrd, maddr, inst, word_at(32'h40));
    end
  endtask

  task automatic test_top_wrap;
    int lat, nrd, rdc;
    logic [31:0] inst, maddr;
    do_reset();
    fetch(32'hFFFFFFF0, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 4 || maddr !== 32'hFFFFFFF0 || inst !== word_at(32'hFFFFFFF0)) begin
      n_fail++;
      $display("FAIL top_miss: got lat=%0d addr=%h inst=%h expected 4 fffffff0 %h", lat, maddr, inst, word_at(32'hFFFFFFF0));
    end
    fetch(32'h00000000, 0, lat, nrd, rdc, inst, maddr);
    n_tests++;
    if (lat !== 1 || nrd !== 0 || inst !== word_at(32'h0)) begin
      n_fail++;
      $display("FAIL wrap_prefetch_hit: got lat=%0d reads=%0d inst=%h expected 1 0 %h", lat, nrd, inst, word_at(32'h0));
    end
  endtask

  task automatic test_random;
    int lat, nrd, rdc, fl = 0;
    logic [31:0] a, inst, maddr;
    bit h;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      a = $urandom_range(0, 9) == 0 ? (32'hFFFFFF00 | 32'($urandom_range(0, 255))) : 32'($urandom_range(0, 1023));
      h = m_hit(a);
      fetch(a, 0, lat, nrd, rdc, inst, maddr);
      n_tests++;
      if (inst !== word_at(a)) begin
        n_fail++;
        $display("FAIL rand_inst[%0d] addr=%h: got %h expected %h", k, a, inst, word_at(a));
      end
      n_tests++;
      if (lat !== (h ? 1 : 4) || nrd !== (h ? 0 : 1) || (!h && maddr !== {a[31:4], 4'h0})) begin
        n_fail++;
        $display("FAIL rand_timing[%0d] addr=%h: got lat=%0d reads=%0d maddr=%h expected hit=%b",
                 k, a, lat, nrd, maddr, h);
      end
      if (!h) m_fill(a);
      if ($urandom_range(0, 19) == 0) begin
        cpu_flush = 1;
        @(posedge clk);
        #1 cpu_flush = 0;
        m_clear();
        fl++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_idx_wrap();
    test_flush_fill();
    test_reset_in_wait();
    test_top_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
